// File: rtl/detect_ctrl.sv
// Sequencer for an external serial "1101" Moore detector: accepts a word, clears the detector,
// streams the word MSB-first, then reports match count, hit flag and first-match index.
module detect_ctrl #(
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned CNT_BITS  = $clog2(WORD_BITS + 1),
  parameter int unsigned IDX_BITS  = $clog2(WORD_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_BITS-1:0] in_data,
  output logic                 det_n_rst,
  output logic                 det_i,
  input  logic                 det_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_BITS-1:0]  out_count,
  output logic                 out_hit,
  output logic [IDX_BITS-1:0]  out_first
);

  typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StReport} state_e;

  localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(WORD_BITS - 1);

  state_e               state_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [IDX_BITS-1:0]  bit_cnt_q;
  logic [CNT_BITS-1:0]  count_q;
  logic                 hit_q;
  logic [IDX_BITS-1:0]  first_q;

  logic                 sample_en;
  logic [IDX_BITS-1:0]  sample_idx;

  // The detector output is registered, so a pulse seen now belongs to the previously sent bit.
  always_comb begin
    sample_en  = 1'b0;
    sample_idx = LastIdx;
    if (state_q == StShift && bit_cnt_q != '0) begin
      sample_en  = det_o;
      sample_idx = bit_cnt_q - IDX_BITS'(1);
    end else if (state_q == StDrain) begin
      sample_en = det_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      first_q   <= '0;
    end else begin
      if (sample_en) begin
        if (count_q != '1) count_q <= count_q + CNT_BITS'(1);
        if (!hit_q) begin
          hit_q   <= 1'b1;
          first_q <= sample_idx;
        end
      end
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            shift_q   <= in_data;
            bit_cnt_q <= '0;
            count_q   <= '0;
            hit_q     <= 1'b0;
            first_q   <= '0;
            state_q   <= StClear;
          end
        end
        StClear: state_q <= StShift;
        StShift: begin
          shift_q   <= {shift_q[WORD_BITS-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + IDX_BITS'(1);
          if (bit_cnt_q == LastIdx) state_q <= StDrain;
        end
        StDrain: state_q <= StReport;
        StReport: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign det_n_rst = !(rst || state_q == StClear);
  assign det_i     = (state_q == StShift) ? shift_q[WORD_BITS-1] : 1'b0;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StReport);
  assign out_count = count_q;
  assign out_hit   = hit_q;
  assign out_first = first_q;

endmodule

// File: tb/tb_detect_ctrl.sv
// Bench for detect_ctrl with a behavioural 1101 detector and a window-scan reference model.
module tb_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, det_n_rst, det_i, det_o, out_valid, out_ready, out_hit;
  logic [15:0] in_data;
  logic [4:0]  out_count;
  logic [3:0]  out_first;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  detect_ctrl #(.WORD_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .det_n_rst (det_n_rst),
    .det_i     (det_i),
    .det_o     (det_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_hit   (out_hit),
    .out_first (out_first)
  );

  // Moore detector: output is high while the last four clocked bits are 1101.
  logic [3:0] hist;
  always @(posedge clk) begin
    if (!det_n_rst) hist <= 4'b0000;
    else            hist <= {hist[2:0], det_i};
  end
  assign det_o = (hist == 4'b1101);

  logic        obs_got;
  int          obs_lat, obs_nlow, obs_nlow_at;
  logic [15:0] obs_stream;
  logic [4:0]  obs_cnt;
  logic        obs_hit;
  logic [3:0]  obs_first;

  int   exp_cnt, exp_first;
  logic exp_hit;

  function automatic void ref_model(input logic [15:0] w, output int cnt, output logic hit,
                                    output int first);
    logic s [16];
    cnt = 0; hit = 1'b0; first = 0;
    for (int j = 0; j < 16; j++) s[j] = w[15-j];
    for (int j = 3; j < 16; j++) begin
      if (s[j-3] && s[j-2] && !s[j-1] && s[j]) begin
        if (cnt < 31) cnt++;
        if (!hit) begin
          hit   = 1'b1;
          first = j;
        end
      end
    end
  endfunction

  // Offer a word from IDLE and follow it until out_valid; cycle 1 is the one after the accept edge.
  task automatic run_word(input logic [15:0] w);
    in_data = w; in_valid = 1'b1;
    obs_got = 1'b0; obs_lat = 0; obs_nlow = 0; obs_nlow_at = -1; obs_stream = '0;
    for (int c = 1; c <= 60 && !obs_got; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      obs_lat  = c;
      if (!det_n_rst) begin
        obs_nlow++;
        if (obs_nlow_at < 0) obs_nlow_at = c;
      end
      if (c >= 2 && c <= 17) obs_stream[17-c] = det_i;
      if (out_valid) obs_got = 1'b1;
    end
    obs_cnt = out_count; obs_hit = out_hit; obs_first = out_first;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hD000; out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (det_n_rst !== 1'b0) begin bad++; $display("FAIL rst_det_n_rst got=%b want=0", det_n_rst); end
    end
    rst = 1'b0; #1;
    total++;
    if ({in_ready, out_valid, out_hit, det_i, det_n_rst} !== 5'b10001) begin
      bad++; $display("FAIL rst_flags got=%b want=10001", {in_ready, out_valid, out_hit, det_i, det_n_rst});
    end
    total++;
    if (out_count !== 5'd0 || out_first !== 4'd0) begin
      bad++; $display("FAIL rst_values got cnt=%0d first=%0d want 0 0", out_count, out_first);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_no_accept in_ready=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    ref_model(16'hD000, exp_cnt, exp_hit, exp_first);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", in_ready); end
    run_word(16'hD000);
    total++;
    if (!obs_got || obs_lat != 19) begin
      bad++; $display("FAIL single_latency got=%0d (valid=%b) want=19", obs_lat, obs_got);
    end
    total++;
    if (obs_stream !== 16'hD000) begin bad++; $display("FAIL single_stream got=%h want=d000", obs_stream); end
    total++;
    if (obs_nlow != 1 || obs_nlow_at != 1) begin
      bad++; $display("FAIL single_clear got=%0d@%0d want=1@1", obs_nlow, obs_nlow_at);
    end
    total++;
    if (obs_cnt !== 5'(exp_cnt) || obs_hit !== exp_hit || obs_first !== 4'(exp_first)) begin
      bad++; $display("FAIL single_result got=%0d/%b/%0d want=%0d/%b/%0d",
                      obs_cnt, obs_hit, obs_first, exp_cnt, exp_hit, exp_first);
    end
    handshake();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL single_return got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_overlap();
    ref_model(16'hDB6D, exp_cnt, exp_hit, exp_first);
    run_word(16'hDB6D);
    total++;
    if (!obs_got || obs_cnt !== 5'(exp_cnt) || obs_hit !== exp_hit || obs_first !== 4'(exp_first)) begin
      bad++; $display("FAIL overlap_result got=%0d/%b/%0d want=%0d/%b/%0d",
                      obs_cnt, obs_hit, obs_first, exp_cnt, exp_hit, exp_first);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    run_word(16'h0000);
    total++;
    if (!obs_got || obs_cnt !== 5'd0 || obs_hit !== 1'b0 || obs_first !== 4'd0) begin
      bad++; $display("FAIL b2b_first got=%0d/%b/%0d want=0/0/0", obs_cnt, obs_hit, obs_first);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy in_ready=%b want=0", in_ready); end
    // Offer the next word during the completing handshake; it must wait for IDLE.
    in_valid = 1'b1; in_data = 16'hFFFF;
    handshake();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    run_word(16'hFFFF);
    total++;
    if (!obs_got || obs_lat != 19 || obs_cnt !== 5'd0 || obs_hit !== 1'b0 || obs_first !== 4'd0) begin
      bad++; $display("FAIL b2b_second got lat=%0d res=%0d/%b/%0d want 19 0/0/0",
                      obs_lat, obs_cnt, obs_hit, obs_first);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    ref_model(16'hB0D0, exp_cnt, exp_hit, exp_first);
    run_word(16'hB0D0);
    in_valid = 1'b1; in_data = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 5'(exp_cnt) ||
          out_hit !== exp_hit || out_first !== 4'(exp_first)) begin
        bad++; $display("FAIL hold_cycle%0d got vld=%b rdy=%b %0d/%b/%0d want 1 0 %0d/%b/%0d", i,
                        out_valid, in_ready, out_count, out_hit, out_first, exp_cnt, exp_hit, exp_first);
      end
    end
    in_valid = 1'b0;
    handshake();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    ref_model(16'h1234, exp_cnt, exp_hit, exp_first);
    run_word(16'h1234);
    total++;
    if (!obs_got || obs_lat != 19 || obs_cnt !== 5'(exp_cnt) || obs_hit !== exp_hit) begin
      bad++; $display("FAIL hold_next got lat=%0d cnt=%0d hit=%b want 19 %0d %b",
                      obs_lat, obs_cnt, obs_hit, exp_cnt, exp_hit);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int seen;
    in_data = 16'hD000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end   // now in SHIFT k=5
    rst = 1'b1; #1;
    total++;
    if (det_n_rst !== 1'b0) begin bad++; $display("FAIL mid_det_n_rst got=%b want=0", det_n_rst); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 5'd0 || out_hit !== 1'b0) begin
      bad++; $display("FAIL mid_idle got rdy=%b vld=%b cnt=%0d hit=%b want 1 0 0 0",
                      in_ready, out_valid, out_count, out_hit);
    end
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", seen); end
    run_word(16'hD000);
    total++;
    if (!obs_got || obs_cnt !== 5'd1 || obs_first !== 4'd3) begin
      bad++; $display("FAIL mid_after got=%0d/%0d want=1/3", obs_cnt, obs_first);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 24; n++) begin
      w = 16'($urandom);
      if (n % 3 == 0) w[15:12] = 4'hD;
      ref_model(w, exp_cnt, exp_hit, exp_first);
      run_word(w);
      total++;
      if (!obs_got || obs_lat != 19 || obs_cnt !== 5'(exp_cnt) || obs_hit !== exp_hit ||
          obs_first !== 4'(exp_first)) begin
        bad++; $display("FAIL rand_%h got lat=%0d %0d/%b/%0d want 19 %0d/%b/%0d", w, obs_lat,
                        obs_cnt, obs_hit, obs_first, exp_cnt, exp_hit, exp_first);
      end
      handshake();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_overlap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
